// File: rtl/avalon_loader.sv
// avalon_loader: boot-time Avalon-MM master that fills the on-chip RAM from a
// byte stream. It then reads the loaded region back and compares checksums.
//
// Bytes are packed little-endian into 32-bit words and written to consecutive
// word addresses starting at 0. The whole region is then read back, and a
// 32-bit additive checksum of the read data is compared with the checksum of
// the written data.
//
// The slave is a plain RAM port with no waitrequest. A write completes in one
// cycle, and read data is returned one cycle after the read strobe.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start, n_words     load request pulse and word count (sampled on accept)
//   byte_in/valid      source byte stream; byte_ready is the handshake back
//   busy, done, err    run status; err holds the last checksum result
//   address ... write  Avalon-MM master signals to the RAM slave
//   readdata           RAM read data (1-cycle latency)

module avalon_loader #(
    parameter int unsigned a_width = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [a_width:0]   n_words,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [a_width-1:0] address,
    output logic               chipselect,
    output logic               write,
    output logic [3:0]         byteenable,
    output logic [31:0]        writedata,
    input  logic [31:0]        readdata
);

    // Counters carry one extra bit so a full region (2^a_width words) is countable
    localparam int unsigned cw = a_width + 1;
    localparam logic [cw-1:0] region_words = cw'(1) << a_width;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        RD,
        RDW,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          byte_take;
    logic [cw-1:0] n_sat;
    logic [cw-1:0] n_last;
    logic [cw-1:0] wcnt;
    logic [cw-1:0] rcnt;
    logic [1:0]    bcnt;
    logic [31:0]   word;
    logic [31:0]   sum_wr;
    logic [31:0]   sum_rd;

    // Requested length clamped to the RAM region
    assign n_sat = (n_words > region_words) ? region_words : n_words;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore outputs; the bus is quiet outside WRITE and RD
    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        byte_take  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        chipselect = 1'b0;
        write      = 1'b0;
        byteenable = 4'h0;
        address    = '0;
        writedata  = 32'h0;

        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = (n_words == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                byte_ready = 1'b1;
                byte_take  = byte_valid;
                if (byte_valid && (bcnt == 2'd3)) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                chipselect = 1'b1;
                write      = 1'b1;
                byteenable = 4'hF;
                address    = wcnt[a_width-1:0];
                writedata  = word;
                state_next = (wcnt == n_last) ? RD : LOAD;
            end
            RD: begin
                chipselect = 1'b1;
                byteenable = 4'hF;
                address    = rcnt[a_width-1:0];
                state_next = RDW;
            end
            RDW: begin
                state_next = (rcnt == n_last) ? DONE : RD;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: word assembly, address counters, checksums, error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            n_last <= '0;
            wcnt   <= '0;
            rcnt   <= '0;
            bcnt   <= 2'd0;
            word   <= 32'h0;
            sum_wr <= 32'h0;
            sum_rd <= 32'h0;
            err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        // n_last is unused when n_words is 0, so its wrap is harmless
                        n_last <= n_sat - cw'(1);
                        wcnt   <= '0;
                        rcnt   <= '0;
                        bcnt   <= 2'd0;
                        sum_wr <= 32'h0;
                        sum_rd <= 32'h0;
                        err    <= 1'b0;
                    end
                end
                LOAD: begin
                    // Shift right so the first byte lands in bits [7:0] after four bytes
                    if (byte_take) begin
                        word <= {byte_in, word[31:8]};
                        bcnt <= bcnt + 2'd1;
                    end
                end
                WRITE: begin
                    sum_wr <= sum_wr + word;
                    if (wcnt == n_last) begin
                        rcnt <= '0;
                    end else begin
                        wcnt <= wcnt + cw'(1);
                    end
                end
                RDW: begin
                    sum_rd <= sum_rd + readdata;
                    if (rcnt != n_last) begin
                        rcnt <= rcnt + cw'(1);
                    end
                end
                DONE: begin
                    err <= (sum_rd != sum_wr);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_loader.sv
// Testbench for avalon_loader.
//
// A RAM slave model sits on the Avalon port and can optionally corrupt word 1
// on read. The driver pushes the expected bus transactions and done events
// into queues. A negedge monitor pops those queues and compares them with
// what the DUT presents.

module tb_avalon_loader;

    localparam int unsigned AW     = 7;
    localparam int unsigned REGION = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   n_words;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] address;
    logic          chipselect;
    logic          write;
    logic [3:0]    byteenable;
    logic [31:0]   writedata;
    logic [31:0]   readdata;

    avalon_loader #(.a_width(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .n_words    (n_words),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .address    (address),
        .chipselect (chipselect),
        .write      (write),
        .byteenable (byteenable),
        .writedata  (writedata),
        .readdata   (readdata)
    );

    always #5 clk = ~clk;

    // RAM slave with registered read data; optional bit-0 flip on word 1
    logic [31:0] mem [REGION];
    logic        corrupt_en;
    always @(posedge clk) begin
        if (chipselect && write) mem[address] <= writedata;
        if (chipselect && !write)
            readdata <= mem[address] ^ ((corrupt_en && address == AW'(1)) ? 32'h1 : 32'h0);
    end

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } bus_t;

    typedef struct {
        int   lat;
        logic err;
    } done_t;

    bus_t  exp_bus[$];
    done_t exp_done[$];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   done_seen = 0;
    logic last_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: compares every bus cycle and done event against the queues
    bus_t  mon_e;
    done_t mon_d;
    logic  err_pending = 1'b0;
    logic  err_exp = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            err_pending = 1'b0;
        end else begin
            if (err_pending) begin
                chk("err_after_done", 64'(err), 64'(err_exp));
                chk("busy_fall", 64'(busy), 64'd0);
                err_pending = 1'b0;
            end
            if (chipselect) begin
                chk("byteenable", 64'(byteenable), 64'hF);
                chk("byte_ready_in_bus", 64'(byte_ready), 64'd0);
                if (exp_bus.size() == 0) begin
                    fail_now("unexpected_bus_cycle");
                end else begin
                    mon_e = exp_bus.pop_front();
                    chk("bus_write_flag", 64'(write), 64'(mon_e.wr));
                    chk("bus_address", 64'(address), 64'(mon_e.addr));
                    if (mon_e.wr) chk("bus_writedata", 64'(writedata), 64'(mon_e.data));
                end
            end else begin
                chk("idle_bus", {27'd0, write, byteenable, address, 32'd0} | 64'(writedata), 64'd0);
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    mon_d = exp_done.pop_front();
                    chk("busy_on_done", 64'(busy), 64'd1);
                    if (mon_d.lat >= 0) chk("done_latency", 64'(cyc - start_cyc), 64'(mon_d.lat));
                    err_exp     = mon_d.err;
                    err_pending = 1'b1;
                end
                done_seen++;
            end
        end
    end

    // One load: mode 0 back-to-back, 1 one byte per three cycles, 2 random gaps
    task automatic run(input int n_req, input int mode, input int pre_idle,
                       input bit corrupt, input bit fixed);
        int          n;
        int          d0;
        int          idx;
        int          t;
        int          k;
        bit          acc;
        logic [31:0] words[$];
        logic [7:0]  bytes[$];
        logic [31:0] w;
        logic [31:0] sum_w;
        logic [31:0] sum_r;
        bus_t        e;
        done_t       d;

        n     = (n_req > int'(REGION)) ? int'(REGION) : n_req;
        sum_w = 32'h0;
        sum_r = 32'h0;
        for (int i = 0; i < n; i++) begin
            w = fixed ? (32'h04030201 + 32'(i) * 32'h04040404) : $urandom;
            words.push_back(w);
            for (int b = 0; b < 4; b++) bytes.push_back(8'(w >> (8 * b)));
            e.wr = 1'b1; e.addr = AW'(i); e.data = w;
            exp_bus.push_back(e);
            sum_w += w;
        end
        for (int i = 0; i < n; i++) begin
            e.wr = 1'b0; e.addr = AW'(i); e.data = 32'h0;
            exp_bus.push_back(e);
            sum_r += words[i] ^ ((corrupt && i == 1) ? 32'h1 : 32'h0);
        end
        d.lat = (mode == 0) ? ((n == 0) ? 1 : 1 + 7 * n + pre_idle) : -1;
        d.err = (sum_r != sum_w);
        exp_done.push_back(d);

        chk("err_held_in_idle", 64'(err), 64'(last_err));
        corrupt_en = corrupt;
        d0         = done_seen;
        start      = 1'b1;
        n_words    = (AW + 1)'(n_req);
        start_cyc  = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_cleared_on_start", 64'(err), 64'd0);
        chk("busy_after_start", 64'(busy), 64'd1);

        if (n > 0) begin
            for (int i = 0; i < pre_idle; i++) begin
                @(negedge clk);
                chk("byte_ready_waiting", 64'(byte_ready), 64'd1);
                @(posedge clk); #1;
            end
        end

        idx = 0; t = 0; k = 0;
        while (idx < 4 * n && t < 20000) begin
            case (mode)
                0:       byte_valid = 1'b1;
                1:       byte_valid = (k % 3 == 0);
                default: byte_valid = 1'($urandom_range(0, 1));
            endcase
            byte_in = bytes[idx];
            @(negedge clk);
            acc = byte_valid && byte_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            k++; t++;
        end
        byte_valid = 1'b0;
        if (idx < 4 * n) fail_now("byte_stream_timeout");

        t = 0;
        while (done_seen == d0 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (done_seen == d0) fail_now("done_timeout");
        @(negedge clk); #1;
        chk("bus_queue_drained", 64'(exp_bus.size()), 64'd0);
        chk("done_queue_drained", 64'(exp_done.size()), 64'd0);
        exp_bus.delete();
        exp_done.delete();
        @(posedge clk); #1;
        last_err = d.err;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_bus"}, {26'd0, chipselect, write, byteenable, address, 32'd0} | 64'(writedata), 64'd0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        n_words    = '0;
        byte_in    = 8'h0;
        byte_valid = 1'b0;
        corrupt_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;

        // Directed loads: idle-first, bytes 01..08, corrupted read-back, error clear
        run(2, 0, 3, 1'b0, 1'b1);
        run(2, 0, 0, 1'b0, 1'b1);
        run(2, 0, 0, 1'b1, 1'b1);
        run(2, 0, 0, 1'b0, 1'b1);
        // Gapped stream, empty load, full region, saturated request
        run(1, 1, 0, 1'b0, 1'b0);
        run(0, 0, 0, 1'b0, 1'b0);
        run(int'(REGION), 0, 0, 1'b0, 1'b0);
        run(200, 2, 0, 1'b1, 1'b0);

        // Reset in LOAD after two bytes, then a fresh load from address 0
        start = 1'b1; n_words = (AW + 1)'(2);
        @(posedge clk); #1;
        start = 1'b0; byte_valid = 1'b1; byte_in = 8'hAA;
        @(posedge clk); #1;
        byte_in = 8'hBB;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        check_all_zero("mid_reset");
        reset = 1'b0;
        last_err = 1'b0;
        @(posedge clk); #1;
        run(2, 0, 0, 1'b0, 1'b0);

        // Randomized loads
        for (int r = 0; r < 12; r++) begin
            run($urandom_range(1, 9), $urandom_range(0, 2), $urandom_range(0, 2),
                1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
